ysyx_220066_cache_axi: RTL and testbench

Line-refill and write-back bridge on the memory side of the data/instruction cache. It accepts the cache's 128-bit line requests, which are held-request, single-cycle-ready transfers. It turns each one into a 2-beat 64-bit AXI4 INCR burst toward the SoC crossbar, then returns the line and its status with a one-cycle ready pulse. Only one transaction is outstanding at a time, and write-backs take priority over refills.

---
 rtl/ysyx_220066_cache_axi_pkg.sv | 25 ++
 rtl/ysyx_220066_cache_axi_if.sv | 66 ++++++
 rtl/ysyx_220066_cache_axi.sv | 147 ++++++++++++++
 tb/tb_ysyx_220066_cache_axi.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_cache_axi_pkg.sv
// Shared types and AXI4 constants for the cache line-refill / write-back bridge.
package ysyx_220066_cache_axi_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRdAr  = 3'd1,
        StRdR   = 3'd2,
        StRdAck = 3'd3,
        StWrReq = 3'd4,
        StWrB   = 3'd5,
        StWrAck = 3'd6
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'b011;
    localparam logic [7:0] LINE_LEN    = 8'd1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [7:0] WSTRB_ALL   = 8'hff;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != RESP_OKAY) && (resp != RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/ysyx_220066_cache_axi_if.sv
// AXI4 master/slave channel bundle between the cache bridge and the SoC crossbar.
interface ysyx_220066_cache_axi_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wvalid;
    logic              wready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface

// File: rtl/ysyx_220066_cache_axi.sv
// Cache line bridge: 128-bit refill/write-back requests to 2-beat 64-bit AXI4 INCR bursts.
// Optional YSYX_220066_AXI_LAST_CHECK_EN flags an rlast/beat mismatch as a read error.
module ysyx_220066_cache_axi
    import ysyx_220066_cache_axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_rd_req,
    input  logic [63:0]  i_rd_addr,
    output logic         o_rd_ready,
    output logic         o_rd_valid,
    output logic [127:0] o_rd_data,
    input  logic         i_wr_req,
    input  logic [63:0]  i_wr_addr,
    input  logic [127:0] i_wr_data,
    output logic         o_wr_ready,
    ysyx_220066_cache_axi_if.master m_axi
);

    state_t              r_state, w_state;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [127:0]        r_wdata, w_wdata;
    logic [127:0]        r_rdata, w_rdata;
    logic [63:0]         r_beat0, w_beat0;
    logic                r_rbeat, w_rbeat;
    logic                r_err, w_err;
    logic                r_aw_done, w_aw_done;
    logic [1:0]          r_wbeat, w_wbeat;
    logic                w_beat_err;

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_rdata    = r_rdata;
        w_beat0    = r_beat0;
        w_rbeat    = r_rbeat;
        w_err      = r_err;
        w_aw_done  = r_aw_done;
        w_wbeat    = r_wbeat;
        w_beat_err = resp_is_err(m_axi.rresp);
`ifdef YSYX_220066_AXI_LAST_CHECK_EN
        w_beat_err = w_beat_err | (m_axi.rlast != r_rbeat);
`endif
        unique case (r_state)
            StIdle: begin
                if (i_wr_req) begin
                    w_addr    = i_wr_addr[ADDR_W-1:0];
                    w_wdata   = i_wr_data;
                    w_aw_done = 1'b0;
                    w_wbeat   = 2'd0;
                    w_state   = StWrReq;
                end else if (i_rd_req) begin
                    w_addr  = i_rd_addr[ADDR_W-1:0];
                    w_rbeat = 1'b0;
                    w_err   = 1'b0;
                    w_state = StRdAr;
                end
            end
            StRdAr: begin
                if (m_axi.arready) w_state = StRdR;
            end
            StRdR: begin
                if (m_axi.rvalid) begin
                    w_err = r_err | w_beat_err;
                    // Stage beat 0 so rd_data only changes once the whole line is in.
                    if (!r_rbeat) begin
                        w_beat0 = m_axi.rdata;
                        w_rbeat = 1'b1;
                    end else begin
                        w_rdata = {m_axi.rdata, r_beat0};
                        w_rbeat = 1'b0;
                        w_state = StRdAck;
                    end
                end
            end
            StRdAck: w_state = StIdle;
            StWrReq: begin
                w_aw_done = r_aw_done | m_axi.awready;
                if (m_axi.wready && !r_wbeat[1]) w_wbeat = r_wbeat + 2'd1;
                if (w_aw_done && w_wbeat[1]) w_state = StWrB;
            end
            StWrB: begin
                if (m_axi.bvalid) w_state = StWrAck;
            end
            StWrAck: w_state = StIdle;
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_beat0   <= '0;
            r_rbeat   <= 1'b0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_wbeat   <= 2'd0;
        end else begin
            r_state   <= w_state;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_rdata   <= w_rdata;
            r_beat0   <= w_beat0;
            r_rbeat   <= w_rbeat;
            r_err     <= w_err;
            r_aw_done <= w_aw_done;
            r_wbeat   <= w_wbeat;
        end
    end

    assign o_rd_ready = (r_state == StRdAck);
    assign o_rd_valid = (r_state == StRdAck) && !r_err;
    assign o_rd_data  = r_rdata;
    assign o_wr_ready = (r_state == StWrAck);

    assign m_axi.arvalid = (r_state == StRdAr);
    assign m_axi.araddr  = r_addr;
    assign m_axi.arid    = {ID_W{1'b0}};
    assign m_axi.arlen   = LINE_LEN;
    assign m_axi.arsize  = SIZE_8B;
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.rready  = (r_state == StRdR);

    assign m_axi.awvalid = (r_state == StWrReq) && !r_aw_done;
    assign m_axi.awaddr  = r_addr;
    assign m_axi.awid    = {ID_W{1'b0}};
    assign m_axi.awlen   = LINE_LEN;
    assign m_axi.awsize  = SIZE_8B;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.wvalid  = (r_state == StWrReq) && !r_wbeat[1];
    assign m_axi.wdata   = r_wbeat[0] ? r_wdata[127:64] : r_wdata[63:0];
    assign m_axi.wstrb   = WSTRB_ALL;
    assign m_axi.wlast   = (r_wbeat == 2'd1);
    assign m_axi.bready  = (r_state == StWrB);

    // Upper address bits, IDs and bresp are intentionally dropped.
    logic w_unused;
    assign w_unused = ^{i_rd_addr, i_wr_addr, m_axi.rid, m_axi.bid, m_axi.bresp, m_axi.rlast};

endmodule

// File: tb/tb_ysyx_220066_cache_axi.sv
// Directed bench for ysyx_220066_cache_axi; the slave side is driven cycle by cycle.
module tb_ysyx_220066_cache_axi;

    logic         i_clk;
    logic         i_rst;
    logic         i_rd_req;
    logic [63:0]  i_rd_addr;
    logic         o_rd_ready;
    logic         o_rd_valid;
    logic [127:0] o_rd_data;
    logic         i_wr_req;
    logic [63:0]  i_wr_addr;
    logic [127:0] i_wr_data;
    logic         o_wr_ready;

    int n_assert = 0;
    int n_fail   = 0;

    ysyx_220066_cache_axi_if #(.ID_W(4), .ADDR_W(32)) axi ();

    ysyx_220066_cache_axi #(.ID_W(4), .ADDR_W(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_req   (i_rd_req),
        .i_rd_addr  (i_rd_addr),
        .o_rd_ready (o_rd_ready),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data),
        .i_wr_req   (i_wr_req),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .o_wr_ready (o_wr_ready),
        .m_axi      (axi)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge where RD_AR is expected; returns at the RD_ACK negedge.
    task automatic serve_read(input logic [31:0] addr, input logic [63:0] d0,
                              input logic [63:0] d1, input logic [1:0] resp0,
                              input logic [1:0] resp1, input logic last0);
        chk("arvalid", axi.arvalid, 1);
        chk("araddr", axi.araddr, addr);
        axi.arready = 1'b1;
        @(negedge i_clk);
        axi.arready = 1'b0;
        chk("rready", axi.rready, 1);
        chk("arvalid_drop", axi.arvalid, 0);
        axi.rvalid = 1'b1; axi.rdata = d0; axi.rresp = resp0; axi.rlast = last0;
        @(negedge i_clk);
        chk("rd_ready_early", o_rd_ready, 0);
        axi.rdata = d1; axi.rresp = resp1; axi.rlast = 1'b1;
        @(negedge i_clk);
        axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rlast = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_rd_req = 1'b0; i_rd_addr = '0; i_wr_req = 1'b0;
        i_wr_addr = '0; i_wr_data = '0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
        axi.rlast = 1'b0; axi.rid = '0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
        repeat (2) @(negedge i_clk);

        // Reset state
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_rd_ready", o_rd_ready, 0);
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_wr_ready", o_wr_ready, 0);
        chk("rst_rd_data", o_rd_data, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Zero-wait refill
        i_rd_req = 1'b1; i_rd_addr = 64'h0000_0000_8000_0010;
        @(negedge i_clk);
        chk("arlen", axi.arlen, 8'd1);
        chk("arsize", axi.arsize, 3'b011);
        chk("arburst", axi.arburst, 2'b01);
        chk("arid", axi.arid, 0);
        serve_read(32'h8000_0010, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   2'b00, 2'b00, 1'b0);
        chk("t1_rd_ready", o_rd_ready, 1);
        chk("t1_rd_valid", o_rd_valid, 1);
        chk("t1_rd_data", o_rd_data, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        i_rd_req = 1'b0;
        @(negedge i_clk);
        chk("t1_rd_ready_pulse", o_rd_ready, 0);
        chk("t1_idle_arvalid", axi.arvalid, 0);

        // SLVERR on beat 1
        i_rd_req = 1'b1; i_rd_addr = 64'h0000_0000_8000_0020;
        @(negedge i_clk);
        serve_read(32'h8000_0020, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
                   2'b00, 2'b10, 1'b0);
        chk("t2_rd_ready", o_rd_ready, 1);
        chk("t2_rd_valid", o_rd_valid, 0);
        i_rd_req = 1'b0;
        @(negedge i_clk);

        // Dirty eviction: write first, then read
        i_rd_req = 1'b1; i_rd_addr = 64'h0000_0000_8000_0100;
        i_wr_req = 1'b1; i_wr_addr = 64'h0000_0000_8000_0200;
        i_wr_data = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        @(negedge i_clk);
        chk("t3_awvalid", axi.awvalid, 1);
        chk("t3_awaddr", axi.awaddr, 32'h8000_0200);
        chk("t3_awlen", axi.awlen, 8'd1);
        chk("t3_wvalid0", axi.wvalid, 1);
        chk("t3_wdata0", axi.wdata, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("t3_wlast0", axi.wlast, 0);
        chk("t3_wstrb", axi.wstrb, 8'hff);
        chk("t3_arvalid_blocked", axi.arvalid, 0);
        axi.awready = 1'b1; axi.wready = 1'b1;
        @(negedge i_clk);
        axi.awready = 1'b0;
        chk("t3_awvalid_done", axi.awvalid, 0);
        chk("t3_wvalid1", axi.wvalid, 1);
        chk("t3_wdata1", axi.wdata, 64'hBBBB_BBBB_BBBB_BBBB);
        chk("t3_wlast1", axi.wlast, 1);
        @(negedge i_clk);
        axi.wready = 1'b0;
        chk("t3_bready", axi.bready, 1);
        chk("t3_wvalid_off", axi.wvalid, 0);
        axi.bvalid = 1'b1;
        @(negedge i_clk);
        axi.bvalid = 1'b0;
        chk("t3_wr_ready", o_wr_ready, 1);
        chk("t3_arvalid_ack", axi.arvalid, 0);
        i_wr_req = 1'b0;
        @(negedge i_clk);
        chk("t3_wr_ready_pulse", o_wr_ready, 0);
        chk("t3_arvalid_idle", axi.arvalid, 0);
        @(negedge i_clk);
        serve_read(32'h8000_0100, 64'h5151_5151_5151_5151, 64'h5252_5252_5252_5252,
                   2'b00, 2'b01, 1'b0);
        chk("t3_rd_valid", o_rd_valid, 1);
        chk("t3_rd_data", o_rd_data, {64'h5252_5252_5252_5252, 64'h5151_5151_5151_5151});
        i_rd_req = 1'b0;
        @(negedge i_clk);

        // awready delayed 3 cycles, wready immediate
        i_wr_req = 1'b1; i_wr_addr = 64'h0000_0000_8000_0300;
        i_wr_data = {64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
        @(negedge i_clk);
        axi.wready = 1'b1;
        chk("t4_awvalid_c1", axi.awvalid, 1);
        chk("t4_wdata0", axi.wdata, 64'hDDDD_DDDD_DDDD_DDDD);
        @(negedge i_clk);
        chk("t4_awvalid_c2", axi.awvalid, 1);
        chk("t4_wdata1", axi.wdata, 64'hCCCC_CCCC_CCCC_CCCC);
        chk("t4_wlast1", axi.wlast, 1);
        @(negedge i_clk);
        axi.wready = 1'b0;
        chk("t4_wvalid_done", axi.wvalid, 0);
        chk("t4_awvalid_c3", axi.awvalid, 1);
        chk("t4_awaddr_hold", axi.awaddr, 32'h8000_0300);
        chk("t4_bready_c3", axi.bready, 0);
        @(negedge i_clk);
        chk("t4_bready_c4", axi.bready, 0);
        axi.awready = 1'b1;
        @(negedge i_clk);
        axi.awready = 1'b0;
        chk("t4_awvalid_off", axi.awvalid, 0);
        chk("t4_bready", axi.bready, 1);
        chk("t4_wr_ready_early", o_wr_ready, 0);
        axi.bvalid = 1'b1;
        @(negedge i_clk);
        axi.bvalid = 1'b0;
        chk("t4_wr_ready", o_wr_ready, 1);
        i_wr_req = 1'b0;
        @(negedge i_clk);
        chk("t4_wr_ready_once_a", o_wr_ready, 0);
        @(negedge i_clk);
        chk("t4_wr_ready_once_b", o_wr_ready, 0);

        // Reset during RD_R beat 0
        i_rd_req = 1'b1; i_rd_addr = 64'h0000_0000_8000_0030;
        @(negedge i_clk);
        chk("t5_arvalid", axi.arvalid, 1);
        axi.arready = 1'b1;
        @(negedge i_clk);
        axi.arready = 1'b0;
        chk("t5_rready", axi.rready, 1);
        axi.rvalid = 1'b1; axi.rdata = 64'h7777_7777_7777_7777;
        i_rst = 1'b1; i_rd_req = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0; axi.rvalid = 1'b0;
        chk("t5_rready_rst", axi.rready, 0);
        chk("t5_arvalid_rst", axi.arvalid, 0);
        chk("t5_awvalid_rst", axi.awvalid, 0);
        chk("t5_wvalid_rst", axi.wvalid, 0);
        chk("t5_bready_rst", axi.bready, 0);
        chk("t5_rd_ready_rst", o_rd_ready, 0);
        chk("t5_wr_ready_rst", o_wr_ready, 0);
        chk("t5_rd_data_rst", o_rd_data, 0);
        i_rd_req = 1'b1; i_rd_addr = 64'h0000_0000_8000_0040;
        @(negedge i_clk);
        serve_read(32'h8000_0040, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   2'b00, 2'b00, 1'b0);
        chk("t5_rd_ready", o_rd_ready, 1);
        chk("t5_rd_valid", o_rd_valid, 1);
        chk("t5_rd_data", o_rd_data, {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
        i_rd_req = 1'b0;
        @(negedge i_clk);

        // rlast asserted early on beat 0
        i_rd_req = 1'b1; i_rd_addr = 64'h0000_0000_8000_0050;
        @(negedge i_clk);
        serve_read(32'h8000_0050, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                   2'b00, 2'b00, 1'b1);
        chk("t6_rd_ready", o_rd_ready, 1);
`ifdef YSYX_220066_AXI_LAST_CHECK_EN
        chk("t6_rd_valid", o_rd_valid, 0);
`else
        chk("t6_rd_valid", o_rd_valid, 1);
`endif
        chk("t6_rd_data", o_rd_data, {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
        i_rd_req = 1'b0;
        @(negedge i_clk);
        chk("t6_rd_ready_pulse", o_rd_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
